riscv_result_checker: RTL and testbench

Synthesizable end-of-program result checker for the RISC-V CHIP environment. It watches the core's instruction address for the end-of-program index and enforces a cycle budget. At program end it scans a parametrised data memory word by word against an expected-answer memory, and reports pass/fail, error count and the first mismatch. It sits beside the core and data memory, on FPGA and emulation builds and in regression benches, where a behavioural final check is unavailable.

---
 rtl/riscv_chk_pkg.sv | 18 +
 rtl/chk_cycle_ctr.sv | 28 ++
 rtl/riscv_result_checker.sv | 156 +++++++++++++++
 tb/tb_riscv_result_checker.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_chk_pkg.sv
// Shared types and default parameters for the end-of-program result checker.
package riscv_chk_pkg;

    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_ADDR_W     = 32;
    localparam int unsigned DEF_DEPTH      = 32;
    localparam int unsigned DEF_IMEM_DEPTH = 32;
    localparam int unsigned DEF_CYC_W      = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        SCAN  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } chk_state_e;

endpackage

// File: rtl/chk_cycle_ctr.sv
// Cycle-budget counter: counts enabled cycles from a clear and flags the last budgeted cycle.
module chk_cycle_ctr
    import riscv_chk_pkg::*;
#(
    parameter int unsigned CYC_W = DEF_CYC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CYC_W-1:0] max,
    output logic             expired_c
);

    logic [CYC_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CYC_W'(1);
        end
    end

    // A zero budget never expires; the counter may wrap harmlessly in that case.
    assign expired_c = enable && (max != '0) && (count == max - CYC_W'(1));

endmodule

// File: rtl/riscv_result_checker.sv
// End-of-program result checker: waits for the end PC or a cycle budget, then
// scans data memory against expected memory. Optional CHECKER_MASK_EN adds a compare mask.
module riscv_result_checker
    import riscv_chk_pkg::*;
#(
    parameter int unsigned  DATA_W     = DEF_DATA_W,
    parameter int unsigned  ADDR_W     = DEF_ADDR_W,
    parameter int unsigned  DEPTH      = DEF_DEPTH,
    parameter int unsigned  IMEM_DEPTH = DEF_IMEM_DEPTH,
    parameter int unsigned  CYC_W      = DEF_CYC_W,
    localparam int unsigned IDX_W      = $clog2(DEPTH),
    localparam int unsigned PIDX_W     = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CYC_W-1:0]  max_cycles,
    input  logic [PIDX_W-1:0] eof_idx,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              rd_en,
    output logic [IDX_W-1:0]  rd_idx,
    input  logic [DATA_W-1:0] rd_data,
    input  logic [DATA_W-1:0] exp_data,
`ifdef CHECKER_MASK_EN
    input  logic [DATA_W-1:0] exp_mask,
`endif
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [IDX_W:0]    err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_exp,
    output logic [DATA_W-1:0] first_err_got
);

    localparam int unsigned CNT_W = IDX_W + 1;

    chk_state_e        state_q;
    logic [CYC_W-1:0]  max_q;
    logic [PIDX_W-1:0] eof_q;
    logic              cmp_valid;
    logic [IDX_W-1:0]  cmp_idx;
    logic              start_ok_c;
    logic              eop_c;
    logic              expired_c;
    logic              mismatch_c;
    logic [CNT_W-1:0]  err_next_c;
    logic              unused_pc;

    assign start_ok_c = start && (state_q == IDLE || state_q == DONE);
    assign eop_c      = (pc_i[PIDX_W+1:2] >= eof_q);
    assign unused_pc  = ^{pc_i[ADDR_W-1:PIDX_W+2], pc_i[1:0]};

    // Read data returns one cycle after rd_en, so compare against last cycle's index.
`ifdef CHECKER_MASK_EN
    assign mismatch_c = cmp_valid && (((rd_data ^ exp_data) & exp_mask) != '0);
`else
    assign mismatch_c = cmp_valid && (rd_data != exp_data);
`endif
    assign err_next_c = err_cnt + CNT_W'(mismatch_c);

    chk_cycle_ctr #(
        .CYC_W (CYC_W)
    ) u_cycle_ctr (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_ok_c),
        .enable    (state_q == RUN),
        .max       (max_q),
        .expired_c (expired_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            max_q          <= '0;
            eof_q          <= '0;
            cmp_valid      <= 1'b0;
            cmp_idx        <= '0;
            rd_en          <= 1'b0;
            rd_idx         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_got  <= '0;
        end else begin
            cmp_valid <= rd_en;
            cmp_idx   <= rd_idx;

            if (mismatch_c) begin
                err_cnt <= err_next_c;
                if (err_cnt == '0) begin
                    first_err_addr <= ADDR_W'({cmp_idx, 2'b00});
                    first_err_exp  <= exp_data;
                    first_err_got  <= rd_data;
                end
            end

            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q        <= RUN;
                        max_q          <= max_cycles;
                        eof_q          <= eof_idx;
                        rd_idx         <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        timeout        <= 1'b0;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                        first_err_exp  <= '0;
                        first_err_got  <= '0;
                    end
                end
                // End of program takes priority over an expiring budget.
                RUN: begin
                    if (eop_c) begin
                        state_q <= SCAN;
                        rd_en   <= 1'b1;
                        rd_idx  <= '0;
                    end else if (expired_c) begin
                        state_q <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                    end
                end
                SCAN: begin
                    if (rd_idx == IDX_W'(DEPTH - 1)) begin
                        state_q <= DRAIN;
                        rd_en   <= 1'b0;
                    end else begin
                        rd_idx <= rd_idx + IDX_W'(1);
                    end
                end
                DRAIN: begin
                    state_q <= DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    pass    <= (err_next_c == '0);
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_result_checker.sv
// Randomized self-checking bench for riscv_result_checker against a reference model.
module tb_riscv_result_checker;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DEPTH      = 32;
    localparam int unsigned IMEM_DEPTH = 32;
    localparam int unsigned CYC_W      = 16;
    localparam int unsigned IDX_W      = 5;
    localparam int unsigned PIDX_W     = 5;
    localparam int          NPC        = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CYC_W-1:0]  max_cycles;
    logic [PIDX_W-1:0] eof_idx;
    logic [ADDR_W-1:0] pc_i;
    logic              rd_en;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] exp_data;
`ifdef CHECKER_MASK_EN
    logic [DATA_W-1:0] exp_mask;
`endif
    logic              busy;
    logic              done;
    logic              pass;
    logic              timeout;
    logic [IDX_W:0]    err_cnt;
    logic [ADDR_W-1:0] first_err_addr;
    logic [DATA_W-1:0] first_err_exp;
    logic [DATA_W-1:0] first_err_got;

    logic [DATA_W-1:0] dmem  [DEPTH];
    logic [DATA_W-1:0] emem  [DEPTH];
    logic [DATA_W-1:0] mmask [DEPTH];
    logic [ADDR_W-1:0] pcs   [NPC];

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    riscv_result_checker dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .max_cycles     (max_cycles),
        .eof_idx        (eof_idx),
        .pc_i           (pc_i),
        .rd_en          (rd_en),
        .rd_idx         (rd_idx),
        .rd_data        (rd_data),
        .exp_data       (exp_data),
`ifdef CHECKER_MASK_EN
        .exp_mask       (exp_mask),
`endif
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .timeout        (timeout),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .first_err_exp  (first_err_exp),
        .first_err_got  (first_err_got)
    );

    // Memories registered on rd_idx: one-cycle read latency.
    always @(posedge clk) begin
        rd_data  <= dmem[rd_idx];
        exp_data <= emem[rd_idx];
`ifdef CHECKER_MASK_EN
        exp_mask <= mmask[rd_idx];
`endif
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_equal();
        for (int k = 0; k < DEPTH; k++) begin
            dmem[k]  = $urandom;
            emem[k]  = dmem[k];
            mmask[k] = '1;
        end
    endtask

    // PC trace: below eof_idx before cycle eop_c, at/above from then on.
    task automatic set_pcs(input int eof, input int eop_c, input bit upper);
        for (int c = 0; c < NPC; c++) begin
            int w;
            if (c < eop_c && eof > 0) w = int'($urandom_range(0, eof - 1));
            else                      w = int'($urandom_range(eof, IMEM_DEPTH - 1));
            pcs[c] = ADDR_W'(4 * w + int'($urandom_range(0, 3)));
            if (upper) pcs[c] = pcs[c] + ADDR_W'(4 * IMEM_DEPTH * int'($urandom_range(0, 7)));
        end
    endtask

    // Reference: end of program is the first RUN cycle whose word index (mod IMEM_DEPTH) reaches eof.
    task automatic model(input int eof, input int maxc, output int e_done, output int e_first,
                         output bit e_to, output int e_errs, output int e_k);
        int c_eop;
        logic [ADDR_W-1:0] p;
        c_eop = -1;
        for (int c = 0; c < 2000 && c_eop < 0; c++) begin
            p = pcs[(c < NPC) ? c : NPC - 1];
            if (int'((p / 4) % IMEM_DEPTH) >= eof) c_eop = c;
        end
        e_errs = 0;
        e_k    = -1;
        if (maxc != 0 && (c_eop < 0 || c_eop >= maxc)) begin
            e_to    = 1'b1;
            e_done  = maxc;
            e_first = -1;
        end else begin
            e_to    = 1'b0;
            e_done  = c_eop + DEPTH + 2;
            e_first = c_eop + 1;
            for (int k = 0; k < DEPTH; k++) begin
                if (((dmem[k] ^ emem[k]) & mmask[k]) != 0) begin
                    if (e_errs == 0) e_k = k;
                    e_errs++;
                end
            end
        end
    endtask

    task automatic run_case(input string name, input int eof, input int maxc, input int abort_idx);
        int  e_done, e_first, e_errs, e_k;
        bit  e_to, idx_ok, e_pass;
        int  rd_cnt, first_rd_n, done_n;
        bit  hit_abort;
        model(eof, maxc, e_done, e_first, e_to, e_errs, e_k);
        @(negedge clk);
        start      = 1'b1;
        max_cycles = CYC_W'(maxc);
        eof_idx    = PIDX_W'(eof);
        @(posedge clk);
        #1;
        start      = 1'b0;
        rd_cnt     = 0;
        first_rd_n = -1;
        done_n     = -1;
        idx_ok     = 1'b1;
        hit_abort  = 1'b0;
        for (int cyc = 0; cyc < e_done + 4; cyc++) begin
            pc_i  = pcs[(cyc < NPC) ? cyc : NPC - 1];
            // A start while busy must be ignored.
            start = (e_done > 6) && (cyc == 3);
            @(posedge clk);
            #1;
            if (rd_en) begin
                if (int'(rd_idx) != rd_cnt) idx_ok = 1'b0;
                if (first_rd_n < 0) first_rd_n = cyc + 1;
                rd_cnt++;
                if (abort_idx >= 0 && int'(rd_idx) == abort_idx) begin
                    hit_abort = 1'b1;
                    break;
                end
            end
            if (done) begin
                done_n = cyc + 1;
                break;
            end
        end
        start = 1'b0;
        if (abort_idx >= 0) begin
            check({name, "_abort_reached"}, 64'(hit_abort), 64'd1);
            rst = 1'b1;
            @(posedge clk);
            #1;
            check({name, "_rst_ctrl"}, 64'({busy, done, pass, timeout, rd_en, rd_idx, err_cnt}), 64'd0);
            check({name, "_rst_first"}, {first_err_addr, first_err_exp | first_err_got}, 64'd0);
            rst = 1'b0;
        end else begin
            e_pass = !e_to && (e_errs == 0);
            check({name, "_done_cycle"}, 64'(done_n), 64'(e_done));
            check({name, "_rd_count"}, 64'(rd_cnt), e_to ? 64'd0 : 64'(DEPTH));
            check({name, "_first_rd"}, 64'(first_rd_n), 64'(e_first));
            check({name, "_rd_idx_seq"}, 64'(idx_ok), 64'd1);
            check({name, "_timeout"}, 64'(timeout), 64'(e_to));
            check({name, "_pass"}, 64'(pass), 64'(e_pass));
            check({name, "_err_cnt"}, 64'(err_cnt), 64'(e_errs));
            check({name, "_busy"}, 64'(busy), 64'd0);
            check({name, "_ferr_addr"}, 64'(first_err_addr), (e_errs > 0) ? 64'(4 * e_k) : 64'd0);
            check({name, "_ferr_exp"}, 64'(first_err_exp), (e_errs > 0) ? 64'(emem[e_k]) : 64'd0);
            check({name, "_ferr_got"}, 64'(first_err_got), (e_errs > 0) ? 64'(dmem[e_k]) : 64'd0);
            repeat (3) @(posedge clk);
            #1;
            check({name, "_hold"}, 64'({done, pass, timeout, err_cnt}),
                  64'({1'b1, e_pass, e_to, 6'(e_errs)}));
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        max_cycles = '0;
        eof_idx    = '0;
        pc_i       = '0;
        fill_equal();
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", 64'({busy, done, pass, timeout, rd_en, rd_idx, err_cnt}), 64'd0);
        check("reset_first", {first_err_addr, first_err_exp | first_err_got}, 64'd0);
        rst = 1'b0;

        // Clean program: end reached at cycle 12.
        for (int c = 0; c < NPC; c++) pcs[c] = (c < 12) ? ADDR_W'(4 * (c % 10)) : ADDR_W'(32'h28);
        run_case("clean", 10, 30, -1);

        // Two differing words.
        dmem[3] = 32'h12; emem[3] = 32'h11;
        dmem[7] = 32'h12; emem[7] = 32'h11;
        run_case("two_err", 10, 30, -1);

        // Program never ends: budget expires.
        fill_equal();
        for (int c = 0; c < NPC; c++) pcs[c] = ADDR_W'(4 * (c % 10));
        run_case("tmo", 10, 30, -1);

        // End of program on the exact expiry cycle.
        for (int c = 0; c < NPC; c++) pcs[c] = (c < 19) ? ADDR_W'(4 * (c % 10)) : ADDR_W'(32'h28);
        run_case("edge", 10, 20, -1);

        // Reset mid-scan, then a full rerun.
        dmem[1] = ~emem[1];
        run_case("abort", 10, 30, 5);
        run_case("rerun", 10, 30, -1);

`ifdef CHECKER_MASK_EN
        fill_equal();
        for (int k = 0; k < DEPTH; k++) mmask[k] = 32'hFFFF0000;
        dmem[2] = emem[2] ^ 32'h0000_A5A5;
        run_case("mask_low", 10, 30, -1);
        dmem[2] = emem[2] ^ 32'h0001_0000;
        run_case("mask_b16", 10, 30, -1);
`endif

        for (int i = 0; i < 10; i++) begin
            int eof, maxc, eop_c, nflip;
            eof   = int'($urandom_range(0, IMEM_DEPTH - 1));
            maxc  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
            eop_c = (maxc == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 50));
            if (eof == 0) eop_c = 0;
            set_pcs(eof, eop_c, 1'b1);
            fill_equal();
`ifdef CHECKER_MASK_EN
            for (int k = 0; k < DEPTH; k++) mmask[k] = $urandom;
`endif
            nflip = int'($urandom_range(0, 3));
            for (int f = 0; f < nflip; f++) begin
                int k;
                k = int'($urandom_range(0, DEPTH - 1));
                dmem[k] = dmem[k] ^ (32'h1 << $urandom_range(0, 31));
            end
            run_case($sformatf("rnd%0d", i), eof, maxc, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
